trigger_link_framer: RTL and testbench

Parametrised per-BX frame builder for the OptoHybrid trigger fibres. It latches one 56-bit cluster word per link each bunch crossing and splits it into four 16-bit GTX words with per-byte K flags. It inserts a sync comma every `SYNC_PERIOD` BX and carries the overflow flag in the comma byte. It sits between cluster packing and the GTX transmitters, replacing per-link fixed framing with N links, per-link enable, resync and an optional test pattern.

---
 rtl/trigger_link_framer.sv | 174 +++++++++++++++++
 tb/tb_trigger_link_framer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_link_framer.sv
// trigger_link_framer: per-BX frame builder for the OptoHybrid trigger fibres.
// Latches one 56-bit cluster word per link on each bx_strobe and serialises it
// as four 16-bit GTX words (word0 carries the comma byte as a K character).
// Optional feature macro: TRIGGER_LINK_TEST_PATTERN_EN (byte-counter test
// pattern selected by test_mode); without it test_mode is ignored.
module trigger_link_framer #(
    parameter int NUM_LINKS   = 4,
    parameter int SYNC_PERIOD = 128
) (
    input  logic                      clk_160,
    input  logic                      reset,
    input  logic                      bx_strobe,
    input  logic [NUM_LINKS*56-1:0]   link_data,
    input  logic                      overflow,
    input  logic [NUM_LINKS-1:0]      link_en,
    input  logic                      resync,
    input  logic                      test_mode,
    output logic [NUM_LINKS*16-1:0]   tx_data,
    output logic [NUM_LINKS*2-1:0]    tx_isk,
    output logic                      ltncy_trig,
    output logic                      align_err
);

    localparam int          CNT_W        = $clog2(SYNC_PERIOD);
    localparam logic [7:0]  K_SYNC       = 8'hFC;
    localparam logic [7:0]  K_OVF        = 8'hF7;
    localparam logic [7:0]  K_IDLE       = 8'hBC;
    localparam logic [7:0]  D_IDLE       = 8'h50;
    localparam logic [55:0] INVALID_WORD = {4{14'h07FF}};
    localparam logic [55:0] IDLE_WORD    = {48'h0, D_IDLE};

    // Word slot within the BX; fc_q names the slot currently on the wire.
    typedef enum logic [1:0] {SLOT_W0, SLOT_W1, SLOT_W2, SLOT_W3} slot_t;

    slot_t                   fc_q;
    slot_t                   word_sel;
    logic [CNT_W-1:0]        bx_cnt_q;
    logic [CNT_W-1:0]        cnt_eff;
    logic                    ovf_pend_q;
    logic                    pend_eff;
    logic                    pend_next;
    logic [7:0]              comma_q;
    logic [7:0]              comma_new;
    logic [7:0]              src_comma;
    logic [NUM_LINKS*56-1:0] data_q;
    logic [NUM_LINKS*56-1:0] data_new;
    logic [NUM_LINKS*56-1:0] src_data;
    logic [NUM_LINKS*16-1:0] tx_data_next;
    logic [NUM_LINKS*2-1:0]  tx_isk_next;
    logic                    trig_next;

    // A resync in the strobe cycle makes this very BX the sync BX.
    assign cnt_eff  = resync ? '0 : bx_cnt_q;
    assign pend_eff = ovf_pend_q | overflow;

    // Comma selection for the BX being latched; sync wins and defers overflow.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        comma_new = K_IDLE;
        pend_next = 1'b0;
        if (cnt_eff == '0) begin
            comma_new = K_SYNC;
            pend_next = pend_eff;
        end else if (pend_eff) begin
            comma_new = K_OVF;
        end
    end

`ifdef TRIGGER_LINK_TEST_PATTERN_EN
    logic [7:0]  tp_q;
    logic [55:0] tp_word;

    // Seven consecutive byte values starting at tp, least significant first.
    always_comb begin
        tp_word = '0;
        for (int b = 0; b < 7; b++) begin
            tp_word[8*b +: 8] = tp_q + 8'(b);
        end
    end

    // Test-pattern base advances by one BX worth of bytes per strobe.
    always_ff @(posedge clk_160 or posedge reset) begin
        if (reset) begin
            tp_q <= 8'h00;
        end else if (bx_strobe) begin
            tp_q <= tp_q + 8'd7;
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
`endif

    // Per-link payload to latch: live data, invalid clusters, or test pattern.
    always_comb begin
        data_new = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            data_new[56*i +: 56] = link_en[i] ? link_data[56*i +: 56] : INVALID_WORD;
        end
`ifdef TRIGGER_LINK_TEST_PATTERN_EN
        if (test_mode) begin
            data_new = {NUM_LINKS{tp_word}};
        end
`endif
    end

    // On a strobe the frame starts from the fresh payload in the same edge.
    assign word_sel  = bx_strobe ? SLOT_W0 : slot_t'(fc_q + 2'd1);
    assign src_data  = bx_strobe ? data_new  : data_q;
    assign src_comma = bx_strobe ? comma_new : comma_q;

    // Slice the selected payload into the GTX word for the upcoming slot.
    always_comb begin
        logic [55:0] l;
        l            = '0;
        tx_data_next = '0;
        tx_isk_next  = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            l = src_data[56*i +: 56];
            case (word_sel)
                SLOT_W0: begin
                    tx_data_next[16*i +: 16] = {l[7:0], src_comma};
                    tx_isk_next[2*i +: 2]    = 2'b01;
                end
                SLOT_W1: tx_data_next[16*i +: 16] = l[23:8];
                SLOT_W2: tx_data_next[16*i +: 16] = l[39:24];
                SLOT_W3: tx_data_next[16*i +: 16] = l[55:40];
            endcase
        end
        trig_next = (word_sel == SLOT_W0) && (src_comma == K_SYNC);
    end

    // BX bookkeeping: frame counter, sync counter, overflow and latched payload.
    always_ff @(posedge clk_160 or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            fc_q       <= SLOT_W3;
            bx_cnt_q   <= '0;
            ovf_pend_q <= 1'b0;
            comma_q    <= K_IDLE;
            data_q     <= {NUM_LINKS{IDLE_WORD}};
            align_err  <= 1'b0;
        end else begin
            fc_q <= word_sel;
            if (bx_strobe) begin
                bx_cnt_q   <= cnt_eff + CNT_W'(1);
                ovf_pend_q <= pend_next;
                comma_q    <= comma_new;
                data_q     <= data_new;
                if (fc_q != SLOT_W3) begin
                    align_err <= 1'b1;
                end
            end else if (resync) begin
                bx_cnt_q <= '0;
            end
        end
    end

    // Registered GTX outputs; reset drops straight to the idle word.
    always_ff @(posedge clk_160 or posedge reset) begin
        if (reset) begin
            tx_data    <= {NUM_LINKS{D_IDLE, K_IDLE}};
            tx_isk     <= {NUM_LINKS{2'b01}};
            ltncy_trig <= 1'b0;
        end else begin
            tx_data    <= tx_data_next;
            tx_isk     <= tx_isk_next;
            ltncy_trig <= trig_next;
        end
    end

endmodule

// File: tb/tb_trigger_link_framer.sv
// Self-checking bench for trigger_link_framer: expected GTX words are queued
// when a BX is driven and popped as the DUT emits them.
module tb_trigger_link_framer;

    localparam int NL = 4;
    localparam int SP = 128;

    logic              clk_160 = 1'b0;
    logic              reset = 1'b1;
    logic              bx_strobe = 1'b0;
    logic [NL*56-1:0]  link_data = '0;
    logic              overflow = 1'b0;
    logic [NL-1:0]     link_en = '1;
    logic              resync = 1'b0;
    logic              test_mode = 1'b0;
    logic [NL*16-1:0]  tx_data;
    logic [NL*2-1:0]   tx_isk;
    logic              ltncy_trig;
    logic              align_err;

    typedef struct {
        logic [NL*16-1:0] data;
        logic [NL*2-1:0]  isk;
        logic             trig;
    } exp_t;

    exp_t             sb[$];
    exp_t             e;
    logic [NL*16-1:0] obs_data[4];
    logic [NL*2-1:0]  obs_isk[4];
    logic             obs_trig[4];
    int               n_checks = 0;
    int               n_errors = 0;

    trigger_link_framer #(.NUM_LINKS(NL), .SYNC_PERIOD(SP)) dut (
        .clk_160   (clk_160),
        .reset     (reset),
        .bx_strobe (bx_strobe),
        .link_data (link_data),
        .overflow  (overflow),
        .link_en   (link_en),
        .resync    (resync),
        .test_mode (test_mode),
        .tx_data   (tx_data),
        .tx_isk    (tx_isk),
        .ltncy_trig(ltncy_trig),
        .align_err (align_err)
    );

    always #5 clk_160 = ~clk_160;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    // Expected words 0..nw-1 of a BX built from payload d, enables en, comma.
    task automatic push_frame(input logic [NL*56-1:0] d, input logic [NL-1:0] en,
                              input logic [7:0] comma, input int nw);
        exp_t        x;
        logic [55:0] l;
        for (int k = 0; k < nw; k++) begin
            x.data = '0;
            x.isk  = '0;
            x.trig = (k == 0) && (comma == 8'hFC);
            for (int i = 0; i < NL; i++) begin
                l = en[i] ? d[56*i +: 56] : {4{14'h07FF}};
                case (k)
                    0: begin
                        x.data[16*i +: 16] = {l[7:0], comma};
                        x.isk[2*i +: 2]    = 2'b01;
                    end
                    1: x.data[16*i +: 16] = l[23:8];
                    2: x.data[16*i +: 16] = l[39:24];
                    default: x.data[16*i +: 16] = l[55:40];
                endcase
            end
            sb.push_back(x);
        end
    endtask

    // Drive one strobe from a negedge and capture the next nw output words.
    task automatic drive_bx(input logic [NL*56-1:0] d, input logic [NL-1:0] en,
                            input logic ovf, input logic rs, input int nw);
        link_data = d;
        link_en   = en;
        overflow  = ovf;
        resync    = rs;
        bx_strobe = 1'b1;
        for (int k = 0; k < nw; k++) begin
            @(negedge clk_160);
            bx_strobe = 1'b0;
            overflow  = 1'b0;
            resync    = 1'b0;
            obs_data[k] = tx_data;
            obs_isk[k]  = tx_isk;
            obs_trig[k] = ltncy_trig;
        end
    endtask

    function automatic logic [NL*56-1:0] rand_data();
        logic [NL*56-1:0] d;
        d = '0;
        for (int j = 0; j < (NL * 56) / 32; j++) d[32*j +: 32] = $urandom;
        return d;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_160);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk_160);
        n_checks++;
        if (tx_data !== {NL{16'h50BC}} || tx_isk !== {NL{2'b01}}) begin
            n_errors++;
            $display("FAIL reset_tx: got %h/%b want %h/%b", tx_data, tx_isk, {NL{16'h50BC}}, {NL{2'b01}});
        end
        n_checks++;
        if (ltncy_trig !== 1'b0 || align_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got trig=%b align=%b want 0/0", ltncy_trig, align_err);
        end
        reset = 1'b0;
        push_frame({NL{56'h50}}, '1, 8'hBC, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_160);
            e = sb.pop_front();
            n_checks++;
            if (tx_data !== e.data || tx_isk !== e.isk || ltncy_trig !== e.trig) begin
                n_errors++;
                $display("FAIL idle w%0d: got %h/%b/%b want %h/%b/%b", k, tx_data, tx_isk, ltncy_trig, e.data, e.isk, e.trig);
            end
        end
    endtask

    task automatic test_basic();
        logic [NL*56-1:0] d;
        do_reset();
        d = rand_data();
        d[55:0] = 56'h0123456789ABCD;
        push_frame(d, '1, 8'hFC, 4);
        drive_bx(d, '1, 1'b0, 1'b0, 4);
        for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            n_checks++;
            if (obs_data[k] !== e.data || obs_isk[k] !== e.isk || obs_trig[k] !== e.trig) begin
                n_errors++;
                $display("FAIL basic w%0d: got %h/%b/%b want %h/%b/%b", k, obs_data[k], obs_isk[k], obs_trig[k], e.data, e.isk, e.trig);
            end
        end
    endtask

    task automatic test_sync_period();
        logic [NL*56-1:0] d;
        int trig_cnt;
        trig_cnt = 0;
        do_reset();
        for (int b = 0; b < 130; b++) begin
            d = rand_data();
            push_frame(d, '1, (b % SP == 0) ? 8'hFC : 8'hBC, 4);
            drive_bx(d, '1, 1'b0, 1'b0, 4);
            for (int k = 0; k < 4; k++) begin
                e = sb.pop_front();
                trig_cnt += int'(obs_trig[k]);
                n_checks++;
                if (obs_data[k] !== e.data || obs_isk[k] !== e.isk || obs_trig[k] !== e.trig) begin
                    n_errors++;
                    $display("FAIL sync bx%0d w%0d: got %h/%b/%b want %h/%b/%b", b, k, obs_data[k], obs_isk[k], obs_trig[k], e.data, e.isk, e.trig);
                end
            end
        end
        n_checks++;
        if (trig_cnt !== 2) begin
            n_errors++;
            $display("FAIL sync_trig_count: got %0d want 2", trig_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [NL*56-1:0] d;
        logic [7:0]       ovf_bx;
        logic [7:0]       commas[8];
        ovf_bx = 8'b1110_0001;
        commas = '{8'hFC, 8'hF7, 8'hBC, 8'hBC, 8'hBC, 8'hF7, 8'hF7, 8'hF7};
        do_reset();
        for (int b = 0; b < 8; b++) begin
            d = rand_data();
            push_frame(d, '1, commas[b], 1);
            drive_bx(d, '1, ovf_bx[b], 1'b0, 4);
            e = sb.pop_front();
            n_checks++;
            if (obs_data[0] !== e.data || obs_trig[0] !== e.trig) begin
                n_errors++;
                $display("FAIL overflow bx%0d: got %h/%b want %h/%b", b, obs_data[0], obs_trig[0], e.data, e.trig);
            end
        end
    endtask

    task automatic test_link_en();
        logic [NL*56-1:0] d;
        d = '1;
        push_frame(d, 4'b1110, 8'hBC, 4);
        drive_bx(d, 4'b1110, 1'b0, 1'b0, 4);
        for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            n_checks++;
            if (obs_data[k] !== e.data || obs_isk[k] !== e.isk) begin
                n_errors++;
                $display("FAIL link_en w%0d: got %h/%b want %h/%b", k, obs_data[k], obs_isk[k], e.data, e.isk);
            end
        end
    endtask

    task automatic test_align_resync();
        logic [NL*56-1:0] d;
        logic [7:0]       commas[4];
        logic [NL*56-1:0] last;
        // Short BX leaves fc = 1, so the following strobe is misaligned.
        d = rand_data();
        push_frame(d, '1, 8'hBC, 2);
        drive_bx(d, '1, 1'b0, 1'b0, 2);
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            n_checks++;
            if (obs_data[k] !== e.data || obs_isk[k] !== e.isk) begin
                n_errors++;
                $display("FAIL short w%0d: got %h/%b want %h/%b", k, obs_data[k], obs_isk[k], e.data, e.isk);
            end
        end
        n_checks++;
        if (align_err !== 1'b0) begin
            n_errors++;
            $display("FAIL align_pre: got %b want 0", align_err);
        end
        // Misaligned strobe with resync, then aligned BX with count 1.
        commas = '{8'hFC, 8'hBC, 8'h00, 8'h00};
        for (int b = 0; b < 2; b++) begin
            d = rand_data();
            last = d;
            push_frame(d, '1, commas[b], 4);
            drive_bx(d, '1, 1'b0, (b == 0), 4);
            for (int k = 0; k < 4; k++) begin
                e = sb.pop_front();
                n_checks++;
                if (obs_data[k] !== e.data || obs_isk[k] !== e.isk || obs_trig[k] !== e.trig) begin
                    n_errors++;
                    $display("FAIL align bx%0d w%0d: got %h/%b/%b want %h/%b/%b", b, k, obs_data[k], obs_isk[k], obs_trig[k], e.data, e.isk, e.trig);
                end
            end
            n_checks++;
            if (align_err !== 1'b1) begin
                n_errors++;
                $display("FAIL align_sticky bx%0d: got %b want 1", b, align_err);
            end
        end
        // Lone resync with no strobe: last frame is resent, next BX is sync.
        push_frame(last, '1, 8'hBC, 4);
        resync = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_160);
            resync = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (tx_data !== e.data || tx_isk !== e.isk || ltncy_trig !== e.trig) begin
                n_errors++;
                $display("FAIL resend w%0d: got %h/%b/%b want %h/%b/%b", k, tx_data, tx_isk, ltncy_trig, e.data, e.isk, e.trig);
            end
        end
        d = rand_data();
        push_frame(d, '1, 8'hFC, 1);
        drive_bx(d, '1, 1'b0, 1'b0, 4);
        e = sb.pop_front();
        n_checks++;
        if (obs_data[0] !== e.data || obs_trig[0] !== e.trig) begin
            n_errors++;
            $display("FAIL resync_sync: got %h/%b want %h/%b", obs_data[0], obs_trig[0], e.data, e.trig);
        end
    endtask

    task automatic test_reset_mid();
        logic [NL*56-1:0] d;
        d = rand_data();
        drive_bx(d, '1, 1'b0, 1'b0, 2);
        reset = 1'b1;
        #1;
        n_checks++;
        if (tx_data !== {NL{16'h50BC}} || tx_isk !== {NL{2'b01}} || align_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: got %h/%b/%b want %h/%b/0", tx_data, tx_isk, align_err, {NL{16'h50BC}}, {NL{2'b01}});
        end
        @(negedge clk_160);
        reset = 1'b0;
        push_frame({NL{56'h50}}, '1, 8'hBC, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_160);
            e = sb.pop_front();
            n_checks++;
            if (tx_data !== e.data || tx_isk !== e.isk || ltncy_trig !== e.trig) begin
                n_errors++;
                $display("FAIL post_reset w%0d: got %h/%b/%b want %h/%b/%b", k, tx_data, tx_isk, ltncy_trig, e.data, e.isk, e.trig);
            end
        end
    endtask

`ifdef TRIGGER_LINK_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [55:0] p;
        logic [7:0]  commas[2];
        commas = '{8'hFC, 8'hBC};
        do_reset();
        test_mode = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < 7; j++) p[8*j +: 8] = 8'(7 * b + j);
            push_frame({NL{p}}, '1, commas[b], 4);
            drive_bx(rand_data(), '0, 1'b0, 1'b0, 4);
            for (int k = 0; k < 4; k++) begin
                e = sb.pop_front();
                n_checks++;
                if (obs_data[k] !== e.data || obs_isk[k] !== e.isk) begin
                    n_errors++;
                    $display("FAIL pattern bx%0d w%0d: got %h/%b want %h/%b", b, k, obs_data[k], obs_isk[k], e.data, e.isk);
                end
            end
        end
        test_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_sync_period();
        test_overflow();
        test_link_en();
        test_align_resync();
        test_reset_mid();
`ifdef TRIGGER_LINK_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
